dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 16x8 data RAM between the CPU (LDA/ADD/STA operand path) and a host
//  port (loader/debugger). One access per clock; registered RAM strobes; read data returned
//  per-port with a valid pulse. Stalls the CPU while it waits. Sits between cpu and data_memory.
// PARAMETERS
//  ADDR_W         4  RAM address width (16 words)
//  DATA_W         8  RAM data width
//  HOST_WAIT_MAX  4  cycles host may lose to CPU before it is forced to win (fixed-priority mode)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  reset       in   1       asynchronous, active-low reset
//  cpu_req     in   1       CPU access request, held until granted
//  cpu_we      in   1       1=write (STA), 0=read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data (ACC)
//  cpu_gnt     out  1       combinational: CPU request accepted this cycle
//  cpu_stall   out  1       cpu_req & ~cpu_gnt
//  cpu_rdata   out  DATA_W  registered read data
//  cpu_rvalid  out  1       one-cycle pulse, cpu_rdata valid
//  host_req/host_we/host_addr/host_wdata/host_gnt/host_rdata/host_rvalid: same as cpu_* (no stall)
//  mem_addr    out  ADDR_W  registered RAM address
//  mem_re      out  1       registered RAM read strobe
//  mem_we      out  1       registered RAM write strobe
//  mem_wdata   out  DATA_W  registered RAM write data
//  mem_rdata   in   DATA_W  RAM read data, valid in same cycle as mem_re
// BEHAVIOUR
//  - Reset (async, reset=0): owner1=owner2=NONE, mem_*=0, *_rdata=0, *_rvalid=0, wait_cnt=0,
//    last_win=HOST. gnt outputs are 0 because owner logic is idle and reqs are masked while in reset.
//    An in-flight access is dropped: no write occurs, no rvalid is issued.
//  - Transfer: req&gnt in cycle N. No dead cycle. Held req = back-to-back accesses, one per cycle.
//  - Pipeline: at end of N, latch addr/we/wdata into mem_*, set mem_re=~we, mem_we=we, owner1=port.
//    Cycle N+1: strobes on RAM; write commits at end of N+1.
//    End of N+1: if owner1 read, capture mem_rdata into <port>_rdata, owner2=port.
//    Cycle N+2: <port>_rvalid=1 for exactly one cycle. Read latency 2; *_rdata holds until next read.
//  - Strobes are 0 in any cycle not preceded by a transfer. No gap is required between accesses.
//  - Owner FSM (owner1, owner2 each in {NONE,CPU,HOST}) advances every cycle; no stall state.
//  - Arbitration (fixed priority, default):
//    - Single requester always wins.
//    - Both requesting: CPU wins unless wait_cnt==HOST_WAIT_MAX, then HOST wins.
//    - wait_cnt++ (saturating) when host_req&cpu_req&~host_gnt.
//    - wait_cnt clears on host_gnt or ~host_req.
//  - Same-address read-after-write across ports: ordering = grant order. A read granted the cycle
//    after a write sees the new data.
//  - Addresses wrap inside ADDR_W bits; no out-of-range case exists.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    - Conflicts go to the port != last_win. last_win updates on every grant.
//    - wait_cnt and HOST_WAIT_MAX are unused (counter is tied to 0).
//    - Single-requester behaviour is unchanged.
//  Undefined: fixed priority with starvation counter as above.
// TESTING
//  1 Host write addr 3 = 0x5A, then CPU read addr 3 -> cpu_gnt same cycle, mem_re=1/mem_addr=3
//    next cycle, cpu_rdata=0x5A with cpu_rvalid 2 cycles after grant.
//  2 cpu_req and host_req both high for one request each in cycle N -> cpu_gnt@N, host_gnt@N+1,
//    cpu_stall=0 throughout, host_rvalid@N+3.
//  3 cpu_req and host_req held continuously (HOST_WAIT_MAX=4) -> cpu_gnt N..N+3, host_gnt@N+4,
//    wait_cnt back to 0 at N+5, CPU wins N+5.
//  4 ARB_ROUND_ROBIN_EN, both held -> grants alternate CPU,HOST,CPU,HOST starting with CPU
//    (last_win=HOST after reset).
//  5 reset asserted the cycle after a CPU write grant -> mem_we=0 immediately, RAM word unchanged,
//    no rvalid; after release all outputs 0.
//  6 CPU write addr 7=0x11 at N, host read addr 7 at N+1 -> host_rdata=0x11, host_rvalid@N+3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the CPU operand path and a host loader/debug port.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin conflict resolution instead of fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 8,
  parameter int HOST_WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  // owner1 tracks the access whose strobes are on the RAM; owner2 the read being returned.
  owner_t owner1;
  owner_t owner2;

  logic cpu_req_m;
  logic host_req_m;

  // Requests are masked during reset so no grant can escape while the pipeline is held clear.
  assign cpu_req_m  = cpu_req  & reset;
  assign host_req_m = host_req & reset;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_win;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (cpu_req_m && host_req_m) begin
      if (last_win == OWN_CPU) host_gnt = 1'b1;
      else                     cpu_gnt  = 1'b1;
    end else begin
      cpu_gnt  = cpu_req_m;
      host_gnt = host_req_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_win <= OWN_HOST;
    end else if (cpu_gnt) begin
      last_win <= OWN_CPU;
    end else if (host_gnt) begin
      last_win <= OWN_HOST;
    end
  end
`else
  localparam int CNT_W = $clog2(HOST_WAIT_MAX + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             host_starved;

  assign host_starved = (wait_cnt == CNT_W'(HOST_WAIT_MAX));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (cpu_req_m && host_req_m) begin
      if (host_starved) host_gnt = 1'b1;
      else              cpu_gnt  = 1'b1;
    end else begin
      cpu_gnt  = cpu_req_m;
      host_gnt = host_req_m;
    end
  end

  // Counts cycles the host has lost to the CPU; saturates at HOST_WAIT_MAX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (host_gnt || !host_req_m) begin
      wait_cnt <= '0;
    end else if (cpu_req_m && !host_starved) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Two-stage access pipeline: grant -> RAM strobes -> read data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner1     <= OWN_NONE;
      owner2     <= OWN_NONE;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      owner1 <= OWN_NONE;
      if (cpu_gnt) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_we    <= cpu_we;
        mem_re    <= ~cpu_we;
        owner1    <= OWN_CPU;
      end else if (host_gnt) begin
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
        mem_we    <= host_we;
        mem_re    <= ~host_we;
        owner1    <= OWN_HOST;
      end

      owner2 <= mem_re ? owner1 : OWN_NONE;
      if (mem_re && owner1 == OWN_CPU)  cpu_rdata  <= mem_rdata;
      if (mem_re && owner1 == OWN_HOST) host_rdata <= mem_rdata;
    end
  end

  assign cpu_rvalid  = (owner2 == OWN_CPU);
  assign host_rvalid = (owner2 == OWN_HOST);

endmodule
